// File: rtl/reg_rename_file_if.sv
// ============================================================================
// Module   : reg_rename_file_if
// Brief    : Issue / commit / source-read bundle for the rename register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_rename_file_if #(
    parameter int XLEN     = 32,
    parameter int IDX_W    = 6,
    parameter int ENTRY_W  = 4,
    parameter int RD_PORTS = 2
);
    logic                        rdy_in;
    logic                        roll_back;
    logic                        new_issue;
    logic [IDX_W-1:0]            rd_in;
    logic [ENTRY_W-1:0]          rob_new_entry;
    logic                        rob_commit;
    logic [IDX_W-1:0]            rob_des;
    logic [ENTRY_W-1:0]          rob_entry;
    logic [XLEN-1:0]             rob_result;
    logic [RD_PORTS*IDX_W-1:0]   rs_idx;
    logic [RD_PORTS-1:0]         q_busy;
    logic [RD_PORTS*ENTRY_W-1:0] q_tag;
    logic [RD_PORTS*XLEN-1:0]    v_val;

    modport master (
        output rdy_in, roll_back, new_issue, rd_in, rob_new_entry,
        output rob_commit, rob_des, rob_entry, rob_result, rs_idx,
        input  q_busy, q_tag, v_val
    );

    modport slave (
        input  rdy_in, roll_back, new_issue, rd_in, rob_new_entry,
        input  rob_commit, rob_des, rob_entry, rob_result, rs_idx,
        output q_busy, q_tag, v_val
    );
endinterface

`default_nettype wire

// File: rtl/reg_rename_file.sv
// ============================================================================
// Module   : reg_rename_file
// Brief    : Architectural register file with busy/ROB-tag rename status and
//            RD_PORTS combinational source-operand read ports.
//            Optional macro REGFILE_BYPASS_EN: commit-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_rename_file #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int IDX_W    = 6,
    parameter int ENTRY_W  = 4,
    parameter int RD_PORTS = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_in,
    reg_rename_file_if.slave  bus
);
    localparam int             SEL_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [IDX_W:0] c_REG_LIM = (IDX_W+1)'(REG_NUM);

    logic [XLEN-1:0]    r_value [REG_NUM];
    logic [ENTRY_W-1:0] r_tag   [REG_NUM];
    logic [REG_NUM-1:0] r_busy;

    logic w_iss_ok;
    logic w_cmt_ok;

    // Register 0 and out-of-range indices never update state.
    assign w_iss_ok = bus.new_issue && !bus.roll_back && (bus.rd_in != '0)
                      && ({1'b0, bus.rd_in} < c_REG_LIM);
    assign w_cmt_ok = bus.rob_commit && (bus.rob_des != '0)
                      && ({1'b0, bus.rob_des} < c_REG_LIM);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else if (bus.rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (w_cmt_ok && (bus.rob_des == IDX_W'(i))) begin
                    r_value[i] <= bus.rob_result;
                    if (r_busy[i] && (r_tag[i] == bus.rob_entry)) begin
                        r_busy[i] <= 1'b0;
                        r_tag[i]  <= '0;
                    end
                end
                // Later assignments override the commit release above.
                if (bus.roll_back) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (w_iss_ok && (bus.rd_in == IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= bus.rob_new_entry;
                end
            end
        end
    end

    logic [RD_PORTS-1:0]         w_q_busy;
    logic [RD_PORTS*ENTRY_W-1:0] w_q_tag;
    logic [RD_PORTS*XLEN-1:0]    w_v_val;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IDX_W-1:0] w_idx;
        logic [SEL_W-1:0] w_sel;
        logic             w_valid;
        logic             w_byp;
        logic             w_pend;

        assign w_idx   = bus.rs_idx[p*IDX_W +: IDX_W];
        assign w_sel   = w_idx[SEL_W-1:0];
        assign w_valid = (w_idx != '0) && ({1'b0, w_idx} < c_REG_LIM);

`ifdef REGFILE_BYPASS_EN
        assign w_byp = bus.rdy_in && !bus.roll_back && bus.rob_commit
                       && (bus.rob_des == w_idx) && r_busy[w_sel]
                       && (r_tag[w_sel] == bus.rob_entry);
`else
        assign w_byp = 1'b0;
`endif

        assign w_pend = w_valid && !w_byp && r_busy[w_sel];

        assign w_q_busy[p]                   = w_pend;
        assign w_q_tag[p*ENTRY_W +: ENTRY_W] = w_pend ? r_tag[w_sel] : '0;
        assign w_v_val[p*XLEN +: XLEN]       = !w_valid ? '0 :
                                               w_byp    ? bus.rob_result :
                                               w_pend   ? '0 : r_value[w_sel];
    end

    assign bus.q_busy = w_q_busy;
    assign bus.q_tag  = w_q_tag;
    assign bus.v_val  = w_v_val;

endmodule

`default_nettype wire

// File: tb/tb_reg_rename_file.sv
// ============================================================================
// Module   : tb_reg_rename_file
// Brief    : Directed self-checking bench for reg_rename_file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_rename_file;
    localparam int XLEN = 32, REG_NUM = 32, IDX_W = 6, ENTRY_W = 4, RD_PORTS = 2;

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    reg_rename_file_if #(.XLEN(XLEN), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W), .RD_PORTS(RD_PORTS)) bus ();

    reg_rename_file #(
        .XLEN(XLEN), .REG_NUM(REG_NUM), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W), .RD_PORTS(RD_PORTS)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [IDX_W-1:0]   rs0;
        logic [IDX_W-1:0]   rs1;
        logic               b0;
        logic [ENTRY_W-1:0] t0;
        logic [XLEN-1:0]    v0;
        logic               b1;
        logic [ENTRY_W-1:0] t1;
        logic [XLEN-1:0]    v1;
    } vec_t;

    vec_t vecs [5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy_in        = 1'b1;
        bus.roll_back     = 1'b0;
        bus.new_issue     = 1'b0;
        bus.rd_in         = '0;
        bus.rob_new_entry = '0;
        bus.rob_commit    = 1'b0;
        bus.rob_des       = '0;
        bus.rob_entry     = '0;
        bus.rob_result    = '0;
    endtask

    task automatic rd(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        bus.rs_idx = {b, a};
        #1;
    endtask

    task automatic issue(input logic [IDX_W-1:0] r, input logic [ENTRY_W-1:0] t);
        bus.new_issue     = 1'b1;
        bus.rd_in         = r;
        bus.rob_new_entry = t;
    endtask

    task automatic commit(input logic [IDX_W-1:0] r, input logic [ENTRY_W-1:0] t,
                          input logic [XLEN-1:0] v);
        bus.rob_commit = 1'b1;
        bus.rob_des    = r;
        bus.rob_entry  = t;
        bus.rob_result = v;
    endtask

    task automatic chk(input string nm, input int p, input logic eb,
                       input logic [ENTRY_W-1:0] et, input logic [XLEN-1:0] ev);
        logic               gb;
        logic [ENTRY_W-1:0] gt;
        logic [XLEN-1:0]    gv;
        gb = bus.q_busy[p];
        gt = bus.q_tag[p*ENTRY_W +: ENTRY_W];
        gv = bus.v_val[p*XLEN +: XLEN];
        n_chk++;
        if ({gb, gt, gv} !== {eb, et, ev}) begin
            n_fail++;
            $display("FAIL %s port%0d: got busy=%0b tag=%0d val=%h, want busy=%0b tag=%0d val=%h",
                     nm, p, gb, gt, gv, eb, et, ev);
        end
    endtask

    initial begin
        idle();
        bus.rs_idx = '0;
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;

        // Reset state
        rd(5, 0);  chk("rst_x5", 0, 0, 0, 0); chk("rst_x0", 1, 0, 0, 0);
        rd(0, 5);  chk("rst_x0", 0, 0, 0, 0); chk("rst_x5", 1, 0, 0, 0);

        // Issue then commit
        issue(3, 2); tick(); idle();
        rd(3, 3); chk("iss_x3", 0, 1, 2, 0); chk("iss_x3", 1, 1, 2, 0);
        rd(1, 1); commit(3, 2, 32'hDEAD); tick(); idle();
        rd(3, 1); chk("cmt_x3", 0, 0, 0, 32'hDEAD);

        // Older commit must not release a newer mapping
        issue(4, 1); tick();
        issue(4, 5); tick(); idle();
        commit(4, 1, 7); tick(); idle();
        rd(4, 0); chk("stale_x4", 0, 1, 5, 0);
        commit(4, 5, 9); tick(); idle();
        rd(4, 0); chk("final_x4", 0, 0, 0, 9);

        // Same-cycle issue and commit to one register
        issue(6, 1); tick(); idle();
        issue(6, 3); commit(6, 1, 32'h11); tick(); idle();
        rd(6, 0); chk("same_x6", 0, 1, 3, 0);

        // Roll back with simultaneous commit and (ignored) issue
        issue(9, 6); tick();
        issue(10, 7); tick();
        issue(7, 8); tick(); idle();
        rd(9, 10); chk("pre_rb_x9", 0, 1, 6, 0); chk("pre_rb_x10", 1, 1, 7, 0);
        bus.roll_back = 1'b1; commit(7, 9, 32'h55); issue(11, 2); tick(); idle();

        vecs[0] = '{rs0: 6,  rs1: 7,  b0: 0, t0: 0, v0: 32'h11,   b1: 0, t1: 0, v1: 32'h55};
        vecs[1] = '{rs0: 9,  rs1: 10, b0: 0, t0: 0, v0: 0,        b1: 0, t1: 0, v1: 0};
        vecs[2] = '{rs0: 11, rs1: 3,  b0: 0, t0: 0, v0: 0,        b1: 0, t1: 0, v1: 32'hDEAD};
        vecs[3] = '{rs0: 4,  rs1: 5,  b0: 0, t0: 0, v0: 9,        b1: 0, t1: 0, v1: 0};
        vecs[4] = '{rs0: 0,  rs1: 63, b0: 0, t0: 0, v0: 0,        b1: 0, t1: 0, v1: 0};
        for (int i = 0; i < 5; i++) begin
            rd(vecs[i].rs0, vecs[i].rs1);
            chk($sformatf("rb_vec%0d", i), 0, vecs[i].b0, vecs[i].t0, vecs[i].v0);
            chk($sformatf("rb_vec%0d", i), 1, vecs[i].b1, vecs[i].t1, vecs[i].v1);
        end

        // x0 is never written or busy
        issue(0, 5); commit(0, 0, 32'hBEEF); tick(); idle();
        rd(0, 0); chk("x0_iss", 0, 0, 0, 0);

        // Stall: state frozen, reads still valid
        bus.rdy_in = 1'b0; issue(12, 3); commit(7, 0, 32'hFF);
        rd(7, 12); chk("stall_rd_x7", 0, 0, 0, 32'h55);
        tick(); idle();
        rd(7, 12); chk("stall_x7", 0, 0, 0, 32'h55); chk("stall_x12", 1, 0, 0, 0);

        // Issuing instruction reads the old mapping of its own rd
        issue(3, 7); rd(3, 0); chk("self_rd_x3", 0, 0, 0, 32'hDEAD);
        tick(); idle();
        rd(3, 0); chk("self_after_x3", 0, 1, 7, 0);

        // Commit-to-read bypass
        issue(8, 4); tick(); idle();
        commit(8, 4, 32'hAB); rd(8, 8);
`ifdef REGFILE_BYPASS_EN
        chk("byp_x8", 0, 0, 0, 32'hAB); chk("byp_x8", 1, 0, 0, 32'hAB);
`else
        chk("nobyp_x8", 0, 1, 4, 0); chk("nobyp_x8", 1, 1, 4, 0);
`endif
        tick(); idle();
        rd(8, 0); chk("after_byp_x8", 0, 0, 0, 32'hAB);

        // Bypass suppressed while stalled
        issue(13, 4); tick(); idle();
        bus.rdy_in = 1'b0; commit(13, 4, 32'hCD); rd(13, 0);
        chk("stall_byp_x13", 0, 1, 4, 0);
        tick(); idle();
        rd(13, 0); chk("stall_lost_x13", 0, 1, 4, 0);

        // Reset mid-stream discards the pending issue/commit
        rst_in = 1'b1; issue(14, 1); commit(13, 4, 32'h77); tick();
        rst_in = 1'b0; idle();
        rd(14, 13); chk("rst_x14", 0, 0, 0, 0); chk("rst_x13", 1, 0, 0, 0);
        rd(7, 3);   chk("rst_x7", 0, 0, 0, 0);  chk("rst_x3", 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
